// File: rtl/alu_result_checker.sv
// Checks ALU samples against an opcode model and tallies pass/fail/skip events,
// capturing the first mismatching sample after each start.
module alu_result_checker #(
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        inValid,
  output logic        inReady,
  input  logic [2:0]  aluOp,
  input  logic [15:0] aIn,
  input  logic [15:0] bIn,
  input  logic [15:0] outPut,
  input  logic        isZero,
  output logic [15:0] passCount,
  output logic [15:0] failCount,
  output logic [15:0] skipCount,
  output logic        failFlag,
  output logic [2:0]  firstFailOp,
  output logic [15:0] firstFailA,
  output logic [15:0] firstFailB,
  output logic [15:0] firstFailGot,
  output logic [15:0] firstFailExp,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [15:0] pass_q, pass_d;
  logic [15:0] fail_q, fail_d;
  logic [15:0] skip_q, skip_d;
  logic        flag_q, flag_d;
  logic [2:0]  cap_op_q, cap_op_d;
  logic [15:0] cap_a_q, cap_a_d;
  logic [15:0] cap_b_q, cap_b_d;
  logic [15:0] cap_got_q, cap_got_d;
  logic [15:0] cap_exp_q, cap_exp_d;

  logic [15:0] exp_result;
  logic        exp_zero;
  logic        checked;
  logic        accept;
  logic        mismatch;

  function automatic logic [15:0] inc_sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Reference result for the checked opcodes; carry/borrow drop out of the 16-bit sum.
  always_comb begin
    exp_result = 16'h0000;
    case (aluOp)
      3'd0:    exp_result = aIn + bIn;
      3'd1:    exp_result = aIn | bIn;
      3'd2:    exp_result = aIn & bIn;
      3'd3:    exp_result = aIn - bIn;
      default: exp_result = 16'h0000;
    endcase
    exp_zero = (exp_result == 16'h0000);
    checked  = ~aluOp[2];
    accept   = inValid && (state_q == StRun);
    mismatch = checked && ((outPut != exp_result) || (isZero != exp_zero));
  end

  // Next-state: start overrides everything, then sample accounting, then stop/halt.
  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    skip_d    = skip_q;
    flag_d    = flag_q;
    cap_op_d  = cap_op_q;
    cap_a_d   = cap_a_q;
    cap_b_d   = cap_b_q;
    cap_got_d = cap_got_q;
    cap_exp_d = cap_exp_q;

    if (start) begin
      // A sample coincident with start is dropped.
      state_d   = StRun;
      pass_d    = '0;
      fail_d    = '0;
      skip_d    = '0;
      flag_d    = 1'b0;
      cap_op_d  = '0;
      cap_a_d   = '0;
      cap_b_d   = '0;
      cap_got_d = '0;
      cap_exp_d = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StRun: begin
          if (accept) begin
            if (!checked) begin
              skip_d = inc_sat(skip_q);
            end else if (mismatch) begin
              fail_d = inc_sat(fail_q);
              flag_d = 1'b1;
              if (!flag_q) begin
                cap_op_d  = aluOp;
                cap_a_d   = aIn;
                cap_b_d   = bIn;
                cap_got_d = outPut;
                cap_exp_d = exp_result;
              end
            end else begin
              pass_d = inc_sat(pass_q);
            end
          end
          // Stop still counts the coincident sample but outranks the halt.
          if (stop) begin
            state_d = StIdle;
          end else if (accept && mismatch && STOP_ON_FAIL) begin
            state_d = StHalt;
          end
        end
        StHalt: begin
          if (stop) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pass_q    <= '0;
      fail_q    <= '0;
      skip_q    <= '0;
      flag_q    <= 1'b0;
      cap_op_q  <= '0;
      cap_a_q   <= '0;
      cap_b_q   <= '0;
      cap_got_q <= '0;
      cap_exp_q <= '0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      skip_q    <= skip_d;
      flag_q    <= flag_d;
      cap_op_q  <= cap_op_d;
      cap_a_q   <= cap_a_d;
      cap_b_q   <= cap_b_d;
      cap_got_q <= cap_got_d;
      cap_exp_q <= cap_exp_d;
    end
  end

  assign inReady      = (state_q == StRun);
  assign busy         = (state_q == StRun);
  assign passCount    = pass_q;
  assign failCount    = fail_q;
  assign skipCount    = skip_q;
  assign failFlag     = flag_q;
  assign firstFailOp  = cap_op_q;
  assign firstFailA   = cap_a_q;
  assign firstFailB   = cap_b_q;
  assign firstFailGot = cap_got_q;
  assign firstFailExp = cap_exp_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: one instance halting on failure, one that keeps
// checking, both driven by the same directed and random samples.
module tb_alu_result_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  alu_op = '0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic [15:0] out_put = '0;
  logic        is_zero = 1'b0;

  logic        h_rdy, h_busy, h_flag;
  logic [15:0] h_pass, h_fail, h_skip, h_fa, h_fb, h_fgot, h_fexp;
  logic [2:0]  h_fop;
  logic        r_rdy, r_busy, r_flag;
  logic [15:0] r_pass, r_fail, r_skip, r_fa, r_fb, r_fgot, r_fexp;
  logic [2:0]  r_fop;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  alu_result_checker #(.STOP_ON_FAIL(1'b1)) u_halt (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .inValid(in_valid),
    .inReady(h_rdy), .aluOp(alu_op), .aIn(a_in), .bIn(b_in), .outPut(out_put),
    .isZero(is_zero), .passCount(h_pass), .failCount(h_fail), .skipCount(h_skip),
    .failFlag(h_flag), .firstFailOp(h_fop), .firstFailA(h_fa), .firstFailB(h_fb),
    .firstFailGot(h_fgot), .firstFailExp(h_fexp), .busy(h_busy)
  );

  alu_result_checker #(.STOP_ON_FAIL(1'b0)) u_run (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .inValid(in_valid),
    .inReady(r_rdy), .aluOp(alu_op), .aIn(a_in), .bIn(b_in), .outPut(out_put),
    .isZero(is_zero), .passCount(r_pass), .failCount(r_fail), .skipCount(r_skip),
    .failFlag(r_flag), .firstFailOp(r_fop), .firstFailA(r_fa), .firstFailB(r_fb),
    .firstFailGot(r_fgot), .firstFailExp(r_fexp), .busy(r_busy)
  );

  // Behavioural model, index 0 = halting instance, 1 = non-halting instance.
  localparam int MIdle = 0, MRun = 1, MHalt = 2;
  int          m_mode [2];
  int          m_pass [2];
  int          m_fail [2];
  int          m_skip [2];
  bit          m_flag [2];
  logic [2:0]  m_fop  [2];
  logic [15:0] m_fa   [2];
  logic [15:0] m_fb   [2];
  logic [15:0] m_fgot [2];
  logic [15:0] m_fexp [2];

  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
    int unsigned r;
    case (op)
      3'd0:    r = (int'(a) + int'(b)) % 65536;
      3'd1:    r = int'(a | b);
      3'd2:    r = int'(a & b);
      3'd3:    r = (int'(a) - int'(b) + 65536) % 65536;
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_clear(input int i, input int mode);
    m_mode[i] = mode;
    m_pass[i] = 0; m_fail[i] = 0; m_skip[i] = 0; m_flag[i] = 0;
    m_fop[i] = '0; m_fa[i] = '0; m_fb[i] = '0; m_fgot[i] = '0; m_fexp[i] = '0;
  endtask

  // One rising edge of behaviour for instance i, from the inputs held before the edge.
  task automatic model_edge(input int i, input bit halt_on_fail);
    logic [15:0] e;
    bit bad;
    if (!rst_n) begin
      model_clear(i, MIdle);
    end else if (start) begin
      model_clear(i, MRun);
    end else if (m_mode[i] == MRun) begin
      bad = 0;
      if (in_valid) begin
        e = ref_result(alu_op, a_in, b_in);
        if (alu_op >= 3'd4) begin
          m_skip[i] = sat(m_skip[i]);
        end else if (out_put != e || is_zero != (e == 16'h0000)) begin
          bad = 1;
          m_fail[i] = sat(m_fail[i]);
          if (!m_flag[i]) begin
            m_fop[i] = alu_op; m_fa[i] = a_in; m_fb[i] = b_in;
            m_fgot[i] = out_put; m_fexp[i] = e;
          end
          m_flag[i] = 1;
        end else begin
          m_pass[i] = sat(m_pass[i]);
        end
      end
      if (stop) m_mode[i] = MIdle;
      else if (bad && halt_on_fail) m_mode[i] = MHalt;
    end else if (m_mode[i] == MHalt && stop) begin
      m_mode[i] = MIdle;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("h.ready", 16'(h_rdy), 16'(m_mode[0] == MRun));
    chk("h.busy",  16'(h_busy), 16'(m_mode[0] == MRun));
    chk("h.pass",  h_pass, 16'(m_pass[0]));
    chk("h.fail",  h_fail, 16'(m_fail[0]));
    chk("h.skip",  h_skip, 16'(m_skip[0]));
    chk("h.flag",  16'(h_flag), 16'(m_flag[0]));
    chk("h.fop",   16'(h_fop), 16'(m_fop[0]));
    chk("h.fa",    h_fa, m_fa[0]);
    chk("h.fb",    h_fb, m_fb[0]);
    chk("h.fgot",  h_fgot, m_fgot[0]);
    chk("h.fexp",  h_fexp, m_fexp[0]);
    chk("r.ready", 16'(r_rdy), 16'(m_mode[1] == MRun));
    chk("r.busy",  16'(r_busy), 16'(m_mode[1] == MRun));
    chk("r.pass",  r_pass, 16'(m_pass[1]));
    chk("r.fail",  r_fail, 16'(m_fail[1]));
    chk("r.skip",  r_skip, 16'(m_skip[1]));
    chk("r.flag",  16'(r_flag), 16'(m_flag[1]));
    chk("r.fop",   16'(r_fop), 16'(m_fop[1]));
    chk("r.fa",    r_fa, m_fa[1]);
    chk("r.fb",    r_fb, m_fb[1]);
    chk("r.fgot",  r_fgot, m_fgot[1]);
    chk("r.fexp",  r_fexp, m_fexp[1]);
  endtask

  // Advance one clock; outputs are compared 1 time unit after the edge.
  task automatic step(input bit do_check);
    model_edge(0, 1'b1);
    model_edge(1, 1'b0);
    @(posedge clk);
    #1;
    if (do_check) check_all();
  endtask

  task automatic drive(input bit v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] o, input logic z);
    in_valid = v; alu_op = op; a_in = a; b_in = b; out_put = o; is_zero = z;
  endtask

  // Random sample; when corrupt is set roughly a third carry a wrong result or flag.
  task automatic rand_sample(input bit corrupt);
    logic [15:0] e;
    int k;
    alu_op = 3'($urandom_range(0, 7));
    a_in = 16'($urandom);
    b_in = ($urandom_range(0, 7) == 0) ? a_in : 16'($urandom);
    e = ref_result(alu_op, a_in, b_in);
    out_put = e;
    is_zero = (e == 16'h0000);
    k = corrupt ? $urandom_range(0, 5) : 5;
    if (k == 0) out_put = 16'($urandom);
    else if (k == 1) is_zero = ~is_zero;
    in_valid = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    model_clear(0, MIdle);
    model_clear(1, MIdle);
    #1 rst_n = 1'b0;
    step(1'b0);
    step(1'b1);  // reset state
    rst_n = 1'b1;

    // IDLE ignores samples and stop.
    drive(1'b1, 3'd0, 16'd1, 16'd1, 16'd2, 1'b0);
    stop = 1'b1;
    step(1'b1);
    stop = 1'b0;

    start = 1'b1; drive(1'b0, 3'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    step(1'b1);
    start = 1'b0;

    drive(1'b1, 3'd0, 16'd1, 16'd1, 16'd2, 1'b0);
    step(1'b1);
    chk("add1p1.pass", h_pass, 16'd1);
    chk("add1p1.busy", 16'(h_busy), 16'd1);
    drive(1'b1, 3'd1, 16'hDDDD, 16'h2222, 16'hFFFF, 1'b0);
    step(1'b1);
    chk("or.pass", h_pass, 16'd2);
    drive(1'b1, 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    step(1'b1);
    chk("addwrap.fail", h_fail, 16'd0);
    drive(1'b1, 3'd5, 16'h1234, 16'h5678, 16'hBEEF, 1'b1);
    step(1'b1);
    chk("op5.skip", h_skip, 16'd1);

    for (int n = 0; n < 40; n++) begin
      rand_sample(1'b0);
      step(1'b1);
    end

    // First mismatch: halting instance stops, the other keeps checking.
    drive(1'b1, 3'd0, 16'd13, 16'd24, 16'd36, 1'b0);
    step(1'b1);
    chk("add13.fexp", h_fexp, 16'h0025);
    chk("add13.fgot", h_fgot, 16'h0024);
    chk("add13.ready", 16'(h_rdy), 16'd0);
    drive(1'b1, 3'd3, 16'd5, 16'd5, 16'd0, 1'b0);  // flag-only mismatch
    step(1'b1);
    drive(1'b1, 3'd2, 16'h00F0, 16'h0F00, 16'h1111, 1'b0);
    step(1'b1);
    chk("cont.fail", r_fail, 16'd3);
    chk("cont.fexp", r_fexp, 16'h0025);

    for (int n = 0; n < 60; n++) begin
      rand_sample(1'b1);
      step(1'b1);
    end

    // Stop with a sample: counted, then IDLE.
    stop = 1'b1; drive(1'b1, 3'd0, 16'd3, 16'd4, 16'd7, 1'b0);
    step(1'b1);
    stop = 1'b0;
    step(1'b1);

    // start and stop together, with a sample: start wins and the sample is dropped.
    start = 1'b1; stop = 1'b1; drive(1'b1, 3'd0, 16'd3, 16'd4, 16'd9, 1'b0);
    step(1'b1);
    start = 1'b0; stop = 1'b0;
    start = 1'b1; drive(1'b1, 3'd0, 16'd3, 16'd4, 16'd7, 1'b0);
    step(1'b1);
    start = 1'b0;

    for (int n = 0; n < 30; n++) begin
      rand_sample(1'b1);
      step(1'b1);
    end

    // Saturation of skipCount.
    start = 1'b1; drive(1'b0, 3'd4, 16'd0, 16'd0, 16'd0, 1'b0);
    step(1'b1);
    start = 1'b0;
    drive(1'b1, 3'd4, 16'd1, 16'd2, 16'd3, 1'b0);
    for (int n = 0; n < 65540; n++) step(1'b0);
    check_all();
    chk("sat.skip", h_skip, 16'hFFFF);

    // Asynchronous reset mid-RUN with a sample presented.
    drive(1'b1, 3'd0, 16'd2, 16'd2, 16'd4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_clear(0, MIdle);
    model_clear(1, MIdle);
    check_all();
    step(1'b1);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) step(1'b1);
    chk("postrst.ready", 16'(r_rdy), 16'd0);

    start = 1'b1; drive(1'b0, 3'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    step(1'b1);
    start = 1'b0;
    drive(1'b1, 3'd3, 16'd9, 16'd4, 16'd5, 1'b0);
    step(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
